disp_scan: RTL and testbench

Time-multiplexed scan controller for a 4-digit common-anode seven-segment display. Latches a 16-bit hex value and cycles through its four nibbles. Each nibble is presented on `digit` to the downstream `sevenseg` decoder while the matching anode is asserted. Value updates take effect only at frame boundaries, so a displayed frame never mixes old and new digits.

---
 rtl/disp_pkg.sv | 19 +
 rtl/disp_scan_if.sv | 24 ++
 rtl/scan_tick.sv | 28 ++
 rtl/disp_scan.sv | 113 +++++++++++
 tb/tb_disp_scan.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/disp_pkg.sv
// Shared constants and helpers for the seven-segment display blocks.
// Anode and decimal-point encodings are active-low throughout.
package disp_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int NIB_W      = 4;
    localparam int VAL_W      = NUM_DIGITS * NIB_W;
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = 4'b1111;
    localparam logic                  DP_OFF   = 1'b1;

    // Active-low one-hot anode pattern for the given slot.
    function automatic logic [NUM_DIGITS-1:0] an_sel(input logic [IDX_W-1:0] idx);
        return ~(NUM_DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/disp_scan_if.sv
// Bus between a display client and the disp_scan controller: value load in,
// scan outputs (digit, anodes, decimal point, frame pulse) out.
interface disp_scan_if;
    import disp_pkg::*;

    logic                  load;
    logic [VAL_W-1:0]      value;
    logic [NUM_DIGITS-1:0] dp_in;
    logic [NIB_W-1:0]      digit;
    logic [NUM_DIGITS-1:0] an;
    logic                  dp;
    logic                  frame_done;

    modport master (
        output load, value, dp_in,
        input  digit, an, dp, frame_done
    );

    modport slave (
        input  load, value, dp_in,
        output digit, an, dp, frame_done
    );

endinterface

// File: rtl/scan_tick.sv
// Free-running prescaler: cnt counts 0..DIV-1 and wraps, tick marks the last count.
module scan_tick #(
    parameter  int unsigned DIV   = 50000,
    localparam int unsigned CNT_W = $clog2(DIV)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             tick,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    assign tick = (cnt == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/disp_scan.sv
// disp_scan: 4-digit common-anode scan controller with frame-aligned value updates.
// Optional leading-zero blanking is enabled by defining DISP_SCAN_LZB_EN.
module disp_scan
    import disp_pkg::*;
#(
    parameter int unsigned DIV   = 50000,
    parameter int unsigned GUARD = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    disp_scan_if.slave bus
);

    localparam int unsigned      CNT_W   = $clog2(DIV);
    localparam logic [CNT_W-1:0] GUARD_C = CNT_W'(GUARD);

    logic                  tick;
    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic                  boundary;

    logic [VAL_W-1:0]      act_val;
    logic [NUM_DIGITS-1:0] act_dp;
    logic [VAL_W-1:0]      pend_val;
    logic [NUM_DIGITS-1:0] pend_dp;
    logic                  pend;

    logic [NUM_DIGITS-1:0] blank;
    logic [NIB_W-1:0]      digit_nx;
    logic [NUM_DIGITS-1:0] an_nx;
    logic                  dp_nx;

    scan_tick #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick),
        .cnt   (cnt)
    );

    assign boundary = tick && (idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (tick) begin
            idx <= idx + 1'b1;
        end
    end

    // Active registers only change at a frame boundary; a load landing on the
    // boundary itself goes straight to active and supersedes the shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: shadow data is reset along with the flag so a load discarded
            // by reset can never resurface on the display.
            act_val  <= '0;
            act_dp   <= '0;
            pend_val <= '0;
            pend_dp  <= '0;
            pend     <= 1'b0;
        end else if (boundary) begin
            if (bus.load) begin
                act_val <= bus.value;
                act_dp  <= bus.dp_in;
            end else if (pend) begin
                act_val <= pend_val;
                act_dp  <= pend_dp;
            end
            pend <= 1'b0;
        end else if (bus.load) begin
            pend_val <= bus.value;
            pend_dp  <= bus.dp_in;
            pend     <= 1'b1;
        end
    end

`ifdef DISP_SCAN_LZB_EN
    // A digit is blank when it and every higher digit are zero; digit 0 never is.
    always_comb begin
        logic hi_zero;
        blank   = '0;
        hi_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            hi_zero  = hi_zero && (act_val[k*NIB_W +: NIB_W] == '0);
            blank[k] = hi_zero;
        end
    end
`else
    assign blank = '0;
`endif

    // NOTE: every combinational output gets a value on every path, so no latch.
    always_comb begin
        digit_nx = act_val[idx*NIB_W +: NIB_W];
        dp_nx    = blank[idx] ? DP_OFF : ~act_dp[idx];
        an_nx    = (cnt < GUARD_C || blank[idx]) ? AN_OFF : an_sel(idx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.digit      <= '0;
            bus.an         <= AN_OFF;
            bus.dp         <= DP_OFF;
            bus.frame_done <= 1'b0;
        end else begin
            bus.digit      <= digit_nx;
            bus.an         <= an_nx;
            bus.dp         <= dp_nx;
            bus.frame_done <= boundary;
        end
    end

endmodule

// File: tb/tb_disp_scan.sv
// Bench for disp_scan (DIV=4, GUARD=1): table-driven frame checks, corner
// sequences and a random load stream against a cycle-count based model.
module tb_disp_scan;

    localparam int DIV   = 4;
    localparam int GUARD = 1;
    localparam int FRAME = 4 * DIV;
`ifdef DISP_SCAN_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    disp_scan_if bus ();

    disp_scan #(.DIV(DIV), .GUARD(GUARD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    // Reference model: position in time since reset decides slot and guard,
    // the active value is whatever was committed at the last frame wrap.
    int          m_n;
    logic [15:0] m_act, m_pval;
    logic [3:0]  m_adp, m_pdp;
    bit          m_pend;
    logic [3:0]  e_digit, e_an;
    logic        e_dp, e_fd;

    task automatic model_reset();
        m_n = 0; m_act = '0; m_adp = '0; m_pval = '0; m_pdp = '0; m_pend = 0;
        e_digit = 4'h0; e_an = 4'hF; e_dp = 1'b1; e_fd = 1'b0;
    endtask

    task automatic model_edge();
        int slot, c;
        bit blank, bnd;
        slot  = (m_n / DIV) % 4;
        c     = m_n % DIV;
        bnd   = (m_n % FRAME) == FRAME - 1;
        blank = LZB && slot > 0 && ((32'(m_act) >> (4 * slot)) == 0);
        e_digit = 4'((32'(m_act) >> (4 * slot)) % 16);
        e_an    = (c < GUARD || blank) ? 4'hF : ~(4'b0001 << slot);
        e_dp    = blank ? 1'b1 : ~m_adp[slot];
        e_fd    = bnd;
        if (bus.load) begin
            if (bnd) begin
                m_act = bus.value; m_adp = bus.dp_in; m_pend = 0;
            end else begin
                m_pval = bus.value; m_pdp = bus.dp_in; m_pend = 1;
            end
        end else if (bnd && m_pend) begin
            m_act = m_pval; m_adp = m_pdp; m_pend = 0;
        end
        m_n++;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("m_digit", 32'(bus.digit), 32'(e_digit));
        check("m_an", 32'(bus.an), 32'(e_an));
        check("m_dp", 32'(bus.dp), 32'(e_dp));
        check("m_frame_done", 32'(bus.frame_done), 32'(e_fd));
        check("an_onehot", 32'($countones(~bus.an) <= 1), 32'd1);
    endtask

    task automatic step_load(input logic [15:0] v, input logic [3:0] d);
        bus.load = 1'b1; bus.value = v; bus.dp_in = d;
        step();
        bus.load = 1'b0;
    endtask

    task automatic advance_to(input int pos);
        int n = 0;
        while ((m_n % FRAME) != pos && n < 2 * FRAME) begin
            step();
            n++;
        end
    endtask

    typedef struct packed {
        logic [15:0]     value;
        logic [3:0]      dp;
        logic [3:0][3:0] d;   // expected digit per slot, [0] = slot 0
        logic [3:0][3:0] a;   // expected anodes per slot
        logic [3:0]      p;   // expected dp pin per slot
    } vec_t;

    task automatic check_slot(input vec_t v, input int s, input string tag);
        advance_to(s * DIV + GUARD);
        step();
        check($sformatf("%s_digit%0d", tag, s), 32'(bus.digit), 32'(v.d[s]));
        check($sformatf("%s_an%0d", tag, s), 32'(bus.an), 32'(v.a[s]));
        check($sformatf("%s_dp%0d", tag, s), 32'(bus.dp), 32'(v.p[s]));
    endtask

    task automatic check_frame(input vec_t v, input string tag);
        advance_to(0);
        for (int s = 0; s < 4; s++) check_slot(v, s, tag);
    endtask

    vec_t tbl [3];
    vec_t v_a, v_5, v_beef, v_zero;
`ifdef DISP_SCAN_LZB_EN
    vec_t v_0050, v_0000;
`endif

    initial begin
        tbl[0] = {16'h1234, 4'b0100, 16'h1234, 16'h7BDE, 4'b1011};
        tbl[1] = {16'h80A7, 4'b1001, 16'h80A7, 16'h7BDE, 4'b0110};
        tbl[2] = {16'hC0DE, 4'b0010, 16'hC0DE, 16'h7BDE, 4'b1101};
        v_a    = {16'hAAAA, 4'b0000, 16'hAAAA, 16'h7BDE, 4'b1111};
        v_5    = {16'h5555, 4'b0000, 16'h5555, 16'h7BDE, 4'b1111};
        v_beef = {16'hBEEF, 4'b0000, 16'hBEEF, 16'h7BDE, 4'b1111};
        v_zero = {16'h0000, 4'b0000, 16'h0000, LZB ? 16'hFFFE : 16'h7BDE, 4'b1111};

        rst_n = 1'b0; bus.load = 1'b0; bus.value = '0; bus.dp_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_an", 32'(bus.an), 32'hF);
        check("rst_dp", 32'(bus.dp), 32'h1);
        check("rst_digit", 32'(bus.digit), 32'h0);
        check("rst_fd", 32'(bus.frame_done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < GUARD; i++) begin
            step();
            check("guard_dark", 32'(bus.an), 32'hF);
        end
        step();
        check("first_lit", 32'(bus.an), 32'hE);

        // Table: each value shown in the frame after it is loaded.
        for (int i = 0; i < 3; i++) begin
            advance_to(3);
            step_load(tbl[i].value, tbl[i].dp);
            check_frame(tbl[i], $sformatf("tbl%0d", i));
        end

        // frame_done period.
        begin
            int w = 0;
            while (!bus.frame_done && w < 3 * FRAME) begin step(); w++; end
            check("fd_seen", 32'(bus.frame_done), 32'd1);
            w = 0;
            do begin step(); w++; end while (!bus.frame_done && w < 3 * FRAME);
            check("fd_period", 32'(w), 32'(FRAME));
        end

        // Tear-free: a load during slot 1 leaves the rest of the frame intact.
        advance_to(3);
        step_load(16'hAAAA, 4'b0000);
        check_frame(v_a, "tear_a");
        advance_to(DIV + GUARD);
        step_load(16'h5555, 4'b0000);
        check_slot(v_a, 2, "tear_old");
        check_slot(v_a, 3, "tear_old");
        check_frame(v_5, "tear_new");

        // Boundary collision: direct load beats a pending one.
        advance_to(3);
        step_load(16'h1111, 4'b1111);
        advance_to(FRAME - 1);
        step_load(16'hBEEF, 4'b0000);
        check_frame(v_beef, "coll");
        check_frame(v_beef, "coll2");

        // Reset mid-frame with a load pending.
        advance_to(3);
        step_load(16'hFFFF, 4'b1111);
        advance_to(2 * DIV + GUARD);
        step();
        rst_n = 1'b0;
        #1;
        check("mrst_an", 32'(bus.an), 32'hF);
        check("mrst_dp", 32'(bus.dp), 32'h1);
        check("mrst_digit", 32'(bus.digit), 32'h0);
        check("mrst_fd", 32'(bus.frame_done), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        check_frame(v_zero, "mrst_f1");
        check_frame(v_zero, "mrst_f2");

`ifdef DISP_SCAN_LZB_EN
        v_0050 = {16'h0050, 4'b1111, 16'h0050, 16'hFFDE, 4'b1100};
        v_0000 = {16'h0000, 4'b0011, 16'h0000, 16'hFFFE, 4'b1110};
        advance_to(3);
        step_load(16'h0050, 4'b1111);
        check_frame(v_0050, "lzb50");
        advance_to(3);
        step_load(16'h0000, 4'b0011);
        check_frame(v_0000, "lzb0");
`endif

        // Random load stream, including loads that land on boundaries.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(5) == 0) begin
                step_load(16'($urandom), 4'($urandom));
            end else begin
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
